pe_result_packer: RTL and testbench

Downstream stage of the PE array dispatcher. It accepts completed PE results (transaction ID, op type, result word) over a valid/ready handshake and buffers them in a small FIFO. It serializes each result into a multi-beat response packet on the narrower chiplet response stream: one header beat, then data beats. It decouples PE completion from response-bus backpressure.

---
 rtl/pe_result_packer.sv | 226 ++++++++++++++++++++++
 tb/tb_pe_result_packer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_packer.sv
// -----------------------------------------------------------------------------
// pe_result_packer
//
// Buffers completed PE results in a small FIFO and serializes each one into a
// response packet on the narrower chiplet response stream: one header beat
// {op_type, trans_id} followed by RES_W/BEAT_W data beats, LSB slice first.
// The FIFO lets PE completion keep going while the response bus stalls.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pe_result_*           result input handshake (trans_id, op_type, data)
//   rsp_data/valid/last   response beat stream, rsp_ready from downstream
//   pkt_count             packets fully sent (wraps)
//   fifo_level            current FIFO occupancy
//
// Optional feature macro: PE_RSP_PARITY_EN
//   Adds rsp_parity (XOR reduction of rsp_data, registered with it) and puts
//   the parity of the full result word in header bit BEAT_W-1.
// -----------------------------------------------------------------------------
module pe_result_packer #(
  parameter int TID_W      = 8,
  parameter int OP_W       = 4,
  parameter int RES_W      = 32,
  parameter int BEAT_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [TID_W-1:0]              pe_result_trans_id,
  input  logic [OP_W-1:0]               pe_result_op_type,
  input  logic [RES_W-1:0]              pe_result_data,
  input  logic                          pe_result_valid,
  output logic                          pe_result_ready,
  output logic [BEAT_W-1:0]             rsp_data,
  output logic                          rsp_valid,
  output logic                          rsp_last,
  input  logic                          rsp_ready,
  output logic [CNT_W-1:0]              pkt_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PE_RSP_PARITY_EN
  ,
  output logic                          rsp_parity
`endif
);

  localparam int N_DATA = RES_W / BEAT_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int IDX_W  = $clog2(N_DATA + 1);
  // Slice table is padded to a power of two so the beat index selects it
  // with a full-width index.
  localparam int NSLICE = 2 ** IDX_W;

  localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DATA);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  // Result storage; contents need no reset because the pointers and level
  // decide what is valid.
  logic [TID_W-1:0] tidMem  [FIFO_DEPTH];
  logic [OP_W-1:0]  opMem   [FIFO_DEPTH];
  logic [RES_W-1:0] dataMem [FIFO_DEPTH];

  logic [AW-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, nextRd;
  logic [LW-1:0]     level_q, level_d;
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  beatIdx_q, beatIdx_d;
  logic              rspValid_q, rspValid_d;
  logic              rspLast_q, rspLast_d;
  logic [BEAT_W-1:0] rspData_q, rspData_d;
  logic [CNT_W-1:0]  pktCount_q, pktCount_d;
  logic              push, pop;
  logic [BEAT_W-1:0] hdrHead, hdrNext;
  logic [BEAT_W-1:0] slices [NSLICE];
`ifdef PE_RSP_PARITY_EN
  logic              rspParity_q, rspParity_d;
`endif

  // Ready depends only on the registered level, so a pop in the same cycle
  // never makes room for a push while full.
  assign pe_result_ready = (level_q != FULL_LVL);
  assign push            = pe_result_valid && pe_result_ready;
  assign nextRd          = rdPtr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (push) begin
      tidMem[wrPtr_q]  <= pe_result_trans_id;
      opMem[wrPtr_q]   <= pe_result_op_type;
      dataMem[wrPtr_q] <= pe_result_data;
    end
  end

  // Header for the current head entry and for the entry behind it; the
  // latter is used when the last data beat pops the head and the next
  // packet starts without an idle cycle.
  always_comb begin
    hdrHead = '0;
    hdrHead[TID_W-1:0]     = tidMem[rdPtr_q];
    hdrHead[TID_W +: OP_W] = opMem[rdPtr_q];
    hdrNext = '0;
    hdrNext[TID_W-1:0]     = tidMem[nextRd];
    hdrNext[TID_W +: OP_W] = opMem[nextRd];
`ifdef PE_RSP_PARITY_EN
    hdrHead[BEAT_W-1] = ^dataMem[rdPtr_q];
    hdrNext[BEAT_W-1] = ^dataMem[nextRd];
`endif
  end

  always_comb begin
    for (int i = 0; i < NSLICE; i++) slices[i] = '0;
    for (int i = 0; i < N_DATA; i++) slices[i] = dataMem[rdPtr_q][i*BEAT_W +: BEAT_W];
  end

  // Packet FSM next state. The output registers are loaded with the beat
  // that will be presented next, so rsp_* only change after a transfer.
  always_comb begin
    state_d    = state_q;
    beatIdx_d  = beatIdx_q;
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
    rspLast_d  = rspLast_q;
    pktCount_d = pktCount_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          state_d    = HDR;
          rspValid_d = 1'b1;
          rspData_d  = hdrHead;
          rspLast_d  = 1'b0;
          beatIdx_d  = '0;
        end
      end
      HDR: begin
        if (rsp_ready) begin
          state_d   = DATA;
          beatIdx_d = IDX_W'(1);
          rspData_d = slices[0];
          rspLast_d = (LAST_IDX == IDX_W'(1));
        end
      end
      DATA: begin
        if (rsp_ready) begin
          if (!rspLast_q) begin
            beatIdx_d = beatIdx_q + 1'b1;
            rspData_d = slices[beatIdx_q];
            rspLast_d = ((beatIdx_q + 1'b1) == LAST_IDX);
          end else begin
            pop        = 1'b1;
            pktCount_d = pktCount_q + 1'b1;
            beatIdx_d  = '0;
            rspLast_d  = 1'b0;
            if (level_q > LW'(1)) begin
              state_d   = HDR;
              rspData_d = hdrNext;
            end else begin
              state_d    = IDLE;
              rspValid_d = 1'b0;
              rspData_d  = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; simultaneous push and pop leave the
  // level unchanged.
  always_comb begin
    wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = pop  ? nextRd         : rdPtr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

`ifdef PE_RSP_PARITY_EN
  assign rspParity_d = ^rspData_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      state_q     <= IDLE;
      beatIdx_q   <= '0;
      rspValid_q  <= 1'b0;
      rspData_q   <= '0;
      rspLast_q   <= 1'b0;
      pktCount_q  <= '0;
`ifdef PE_RSP_PARITY_EN
      rspParity_q <= 1'b0;
`endif
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      beatIdx_q   <= beatIdx_d;
      rspValid_q  <= rspValid_d;
      rspData_q   <= rspData_d;
      rspLast_q   <= rspLast_d;
      pktCount_q  <= pktCount_d;
`ifdef PE_RSP_PARITY_EN
      rspParity_q <= rspParity_d;
`endif
    end
  end

  assign rsp_valid  = rspValid_q;
  assign rsp_data   = rspData_q;
  assign rsp_last   = rspLast_q;
  assign pkt_count  = pktCount_q;
  assign fifo_level = level_q;
`ifdef PE_RSP_PARITY_EN
  assign rsp_parity = rspParity_q;
`endif

endmodule

// File: tb/tb_pe_result_packer.sv
// -----------------------------------------------------------------------------
// tb_pe_result_packer
//
// Self-checking bench for pe_result_packer. A reference model turns every
// accepted result into its expected beat list (header, then LSB-first data
// slices) and tracks FIFO occupancy from pushes and completed packets.
// -----------------------------------------------------------------------------
module tb_pe_result_packer;

  localparam int TID_W      = 8;
  localparam int OP_W       = 4;
  localparam int RES_W      = 32;
  localparam int BEAT_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
  localparam int N_DATA     = RES_W / BEAT_W;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [TID_W-1:0]  pe_result_trans_id = '0;
  logic [OP_W-1:0]   pe_result_op_type = '0;
  logic [RES_W-1:0]  pe_result_data = '0;
  logic              pe_result_valid = 1'b0;
  logic              pe_result_ready;
  logic [BEAT_W-1:0] rsp_data;
  logic              rsp_valid;
  logic              rsp_last;
  logic              rsp_ready = 1'b0;
  logic [CNT_W-1:0]  pkt_count;
  logic [LVL_W-1:0]  fifo_level;
`ifdef PE_RSP_PARITY_EN
  logic              rsp_parity;
  logic              sPar;
`endif

  pe_result_packer #(
    .TID_W(TID_W), .OP_W(OP_W), .RES_W(RES_W), .BEAT_W(BEAT_W),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pe_result_trans_id(pe_result_trans_id),
    .pe_result_op_type(pe_result_op_type),
    .pe_result_data(pe_result_data),
    .pe_result_valid(pe_result_valid),
    .pe_result_ready(pe_result_ready),
    .rsp_data(rsp_data),
    .rsp_valid(rsp_valid),
    .rsp_last(rsp_last),
    .rsp_ready(rsp_ready),
    .pkt_count(pkt_count),
    .fifo_level(fifo_level)
`ifdef PE_RSP_PARITY_EN
    ,
    .rsp_parity(rsp_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BEAT_W-1:0] d;
    logic              l;
  } beat_t;

  beat_t expQ[$];
  int    checks = 0;
  int    errors = 0;
  int    modelLevel = 0;
  int    pushedCnt = 0;

  logic              sValid, sLast, sBeat, sPush;
  logic [BEAT_W-1:0] sData;

  // Expected packet for one result: header value tid + op*2^TID_W (plus the
  // data parity in the top bit when enabled), then the data word cut into
  // BEAT_W pieces starting from the least significant one.
  task automatic enqueueResult(input logic [TID_W-1:0] tid, input logic [OP_W-1:0] op,
                               input logic [RES_W-1:0] data);
    beat_t b;
    b.d = BEAT_W'(int'(tid) + int'(op) * (1 << TID_W));
`ifdef PE_RSP_PARITY_EN
    if ($countones(data) % 2 == 1) b.d = b.d | BEAT_W'(1 << (BEAT_W - 1));
`endif
    b.l = 1'b0;
    expQ.push_back(b);
    for (int k = 0; k < N_DATA; k++) begin
      b.d = BEAT_W'(data >> (k * BEAT_W));
      b.l = (k == N_DATA - 1);
      expQ.push_back(b);
    end
  endtask

  // Advance one clock: sample at the falling edge, update the model with any
  // push the model allows and any completed packet, then return 1 after the
  // next rising edge.
  task automatic cycle();
    @(negedge clk);
    sValid = rsp_valid;
    sData  = rsp_data;
    sLast  = rsp_last;
`ifdef PE_RSP_PARITY_EN
    sPar   = rsp_parity;
`endif
    sBeat  = rsp_valid && rsp_ready;
    sPush  = pe_result_valid && (modelLevel != FIFO_DEPTH);
    if (sPush) begin
      enqueueResult(pe_result_trans_id, pe_result_op_type, pe_result_data);
      modelLevel++;
      pushedCnt++;
    end
    if (sBeat && rsp_last) modelLevel--;
    @(posedge clk);
    #1;
  endtask

  task automatic driveResult(input logic [TID_W-1:0] tid, input logic [OP_W-1:0] op,
                             input logic [RES_W-1:0] data);
    pe_result_trans_id = tid;
    pe_result_op_type  = op;
    pe_result_data     = data;
    pe_result_valid    = 1'b1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    pe_result_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    expQ.delete();
    modelLevel = 0;
    pushedCnt = 0;
  endtask

  task automatic test_reset();
    doReset();
    checks += 6;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", rsp_valid); end
    if (rsp_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", rsp_last); end
    if (rsp_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", rsp_data); end
    if (pkt_count !== '0) begin errors++; $display("[TB] FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
    if (fifo_level !== '0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
    if (pe_result_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", pe_result_ready); end
  endtask

  task automatic test_single();
    logic [BEAT_W-1:0] want [3];
    beat_t e;
    want[0] = 16'h035A; want[1] = 16'hBEEF; want[2] = 16'hDEAD;
    rsp_ready = 1'b1;
    driveResult(8'h5A, 4'h3, 32'hDEADBEEF);
    cycle();
    pe_result_valid = 1'b0;
    checks += 2;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %b expected 0", rsp_valid); end
    if (fifo_level !== LVL_W'(1)) begin errors++; $display("[TB] FAIL single_level: got %0d expected 1", fifo_level); end
    cycle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h035A) begin
      errors++; $display("[TB] FAIL single_hdr_latency: got valid %b data %h expected 1/035a", rsp_valid, rsp_data);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (!sBeat || sData !== want[i] || sLast !== (i == 2)) begin
        errors++; $display("[TB] FAIL single_beat%0d: got %b/%h/%b expected 1/%h/%b", i, sBeat, sData, sLast, want[i], i == 2);
      end
      if (expQ.size() != 0) e = expQ.pop_front();
    end
    checks += 2;
    if (pkt_count !== CNT_W'(1)) begin errors++; $display("[TB] FAIL single_pkt_count: got %0d expected 1", pkt_count); end
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_full();
    beat_t e;
    int budget;
    logic pending;
    rsp_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      driveResult(TID_W'($urandom()), OP_W'($urandom()), RES_W'($urandom()));
      cycle();
    end
    pe_result_valid = 1'b0;
    checks += 2;
    if (fifo_level !== LVL_W'(FIFO_DEPTH)) begin errors++; $display("[TB] FAIL full_level: got %0d expected %0d", fifo_level, FIFO_DEPTH); end
    if (pe_result_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b expected 0", pe_result_ready); end
    driveResult(TID_W'($urandom()), OP_W'($urandom()), RES_W'($urandom()));
    pending = 1'b1;
    rsp_ready = 1'b1;
    budget = 200;
    while ((expQ.size() != 0 || pending) && budget > 0) begin
      budget--;
      checks++;
      if (pe_result_ready !== (modelLevel != FIFO_DEPTH)) begin
        errors++; $display("[TB] FAIL full_hold_ready: got %b expected %b", pe_result_ready, modelLevel != FIFO_DEPTH);
      end
      cycle();
      if (sPush) begin pe_result_valid = 1'b0; pending = 1'b0; end
      if (sBeat) begin
        checks++;
        if (expQ.size() == 0) begin errors++; $display("[TB] FAIL full_beat: got %h expected no beat", sData); end
        else begin
          e = expQ.pop_front();
          if (sData !== e.d || sLast !== e.l) begin
            errors++; $display("[TB] FAIL full_beat: got %h/%b expected %h/%b", sData, sLast, e.d, e.l);
          end
        end
      end
    end
    checks += 2;
    if (budget == 0) begin errors++; $display("[TB] FAIL full_timeout: got %0d beats left expected 0", expQ.size()); end
    if (pkt_count !== CNT_W'(pushedCnt)) begin errors++; $display("[TB] FAIL full_pkt_count: got %0d expected %0d", pkt_count, pushedCnt); end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    int beatNum = 0;
    int cyc = 0;
    rsp_ready = 1'b1;
    while (beatNum < 3 * (N_DATA + 1) && cyc < 100) begin
      if (cyc < 3) driveResult(TID_W'($urandom()), OP_W'($urandom()), RES_W'($urandom()));
      else pe_result_valid = 1'b0;
      cyc++;
      cycle();
      if (beatNum > 0 && !sBeat) begin
        checks++; errors++; $display("[TB] FAIL b2b_gap: got no beat after beat %0d expected continuous", beatNum);
      end
      if (sBeat) begin
        beatNum++;
        checks++;
        if (sLast !== (beatNum % (N_DATA + 1) == 0)) begin
          errors++; $display("[TB] FAIL b2b_last: beat %0d got %b expected %b", beatNum, sLast, beatNum % (N_DATA + 1) == 0);
        end
        checks++;
        if (expQ.size() == 0) begin errors++; $display("[TB] FAIL b2b_beat: got %h expected no beat", sData); end
        else begin
          e = expQ.pop_front();
          if (sData !== e.d) begin errors++; $display("[TB] FAIL b2b_beat: got %h expected %h", sData, e.d); end
        end
      end
    end
    checks++;
    if (beatNum != 3 * (N_DATA + 1)) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", beatNum, 3 * (N_DATA + 1)); end
  endtask

  task automatic test_random_stall();
    beat_t e;
    int pushIdx = 0;
    int pktBeat = 0;
    int budget = 400;
    logic prevStall = 1'b0;
    logic [BEAT_W-1:0] prevData = '0;
    logic prevLast = 1'b0;
    while ((pushIdx < 4 || pe_result_valid || expQ.size() != 0) && budget > 0) begin
      budget--;
      if (!pe_result_valid && pushIdx < 4 && ($urandom() % 3 == 0)) begin
        driveResult(TID_W'($urandom()), OP_W'($urandom()), RES_W'($urandom()));
        pushIdx++;
      end
      rsp_ready = ($urandom() % 2 == 1);
      cycle();
      if (sPush) pe_result_valid = 1'b0;
      if (prevStall) begin
        checks++;
        if (sValid !== 1'b1 || sData !== prevData || sLast !== prevLast) begin
          errors++; $display("[TB] FAIL stall_stable: got %b/%h/%b expected 1/%h/%b", sValid, sData, sLast, prevData, prevLast);
        end
      end
      if (pktBeat != 0) begin
        checks++;
        if (sValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid_drop: got %b expected 1", sValid); end
      end
      prevStall = sValid && !sBeat;
      prevData = sData;
      prevLast = sLast;
      if (sBeat) begin
        pktBeat = sLast ? 0 : pktBeat + 1;
        checks++;
        if (expQ.size() == 0) begin errors++; $display("[TB] FAIL stall_beat: got %h expected no beat", sData); end
        else begin
          e = expQ.pop_front();
          if (sData !== e.d || sLast !== e.l) begin
            errors++; $display("[TB] FAIL stall_beat: got %h/%b expected %h/%b", sData, sLast, e.d, e.l);
          end
        end
      end
    end
    checks++;
    if (budget == 0) begin errors++; $display("[TB] FAIL stall_timeout: got %0d beats left expected 0", expQ.size()); end
  endtask

  task automatic test_reset_mid();
    beat_t e;
    int budget = 50;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      driveResult(TID_W'($urandom()), OP_W'($urandom()), RES_W'($urandom()));
      cycle();
    end
    pe_result_valid = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || fifo_level !== LVL_W'(3)) begin
      errors++; $display("[TB] FAIL rmid_setup: got valid %b level %0d expected 1/3", rsp_valid, fifo_level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid: got %b expected 0", rsp_valid); end
    if (fifo_level !== '0) begin errors++; $display("[TB] FAIL rmid_level: got %0d expected 0", fifo_level); end
    if (pkt_count !== '0) begin errors++; $display("[TB] FAIL rmid_pkt_count: got %0d expected 0", pkt_count); end
    if (rsp_last !== 1'b0) begin errors++; $display("[TB] FAIL rmid_last: got %b expected 0", rsp_last); end
    expQ.delete();
    modelLevel = 0;
    pushedCnt = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (sValid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_stale: got valid %b data %h expected 0", sValid, sData); end
    end
    driveResult(TID_W'($urandom()), OP_W'($urandom()), RES_W'($urandom()));
    cycle();
    pe_result_valid = 1'b0;
    while (expQ.size() != 0 && budget > 0) begin
      budget--;
      cycle();
      if (sBeat) begin
        e = expQ.pop_front();
        checks++;
        if (sData !== e.d || sLast !== e.l) begin
          errors++; $display("[TB] FAIL rmid_beat: got %h/%b expected %h/%b", sData, sLast, e.d, e.l);
        end
      end
    end
    checks += 2;
    if (budget == 0) begin errors++; $display("[TB] FAIL rmid_timeout: got %0d beats left expected 0", expQ.size()); end
    if (pkt_count !== CNT_W'(1)) begin errors++; $display("[TB] FAIL rmid_pkt_count_after: got %0d expected 1", pkt_count); end
  endtask

`ifdef PE_RSP_PARITY_EN
  task automatic test_parity();
    beat_t e;
    int budget = 60;
    int beatNum = 0;
    rsp_ready = 1'b1;
    driveResult(TID_W'($urandom()), OP_W'($urandom()), 32'h00000001);
    cycle();
    driveResult(TID_W'($urandom()), OP_W'($urandom()), 32'h1234BEEF);
    cycle();
    pe_result_valid = 1'b0;
    while (expQ.size() != 0 && budget > 0) begin
      budget--;
      cycle();
      if (sBeat) begin
        beatNum++;
        e = expQ.pop_front();
        checks += 2;
        if (sData !== e.d || sLast !== e.l) begin
          errors++; $display("[TB] FAIL par_beat: got %h/%b expected %h/%b", sData, sLast, e.d, e.l);
        end
        if (sPar !== ($countones(e.d) % 2 == 1)) begin
          errors++; $display("[TB] FAIL par_bit: beat %h got %b expected %b", e.d, sPar, $countones(e.d) % 2 == 1);
        end
        if (beatNum == 1) begin
          checks++;
          if (sData[BEAT_W-1] !== 1'b1) begin errors++; $display("[TB] FAIL par_hdr_bit: got %b expected 1", sData[BEAT_W-1]); end
        end
      end
    end
    checks++;
    if (budget == 0) begin errors++; $display("[TB] FAIL par_timeout: got %0d beats left expected 0", expQ.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
`ifdef PE_RSP_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
